router_sync_n: RTL and testbench

Parametrised N-port synchronizer for the packet router, sitting between the router FSM/register block and the per-port output FIFOs. It latches the destination address of each packet and steers the write enable to the addressed FIFO, muxing that FIFO's full flag back to the FSM. It drives per-port valid flags and issues a one-cycle soft reset to any FIFO whose data sits unread for TIMEOUT cycles. It generalises the fixed 3-port synchronizer with arbitrary port count, a configurable timeout, address-range checking and optional timeout statistics.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_sync_timer.sv | 68 ++++++
 rtl/router_sync_n.sv | 60 ++++++
 tb/tb_router_sync_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants, address type and stat helper.
// Used by the router FSM, register block and synchronizer.
package router_pkg;

  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_TIMEOUT   = 30;
  localparam int STAT_W        = 8;

  typedef logic [DEF_ADDR_W-1:0] addr_t;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// One port's unread-data timeout counter and soft reset pulse.
// Optional saturating event counter under ROUTER_SYNC_STAT_EN.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic              i_rd,
  output logic              o_soft_reset,
  output logic [STAT_W-1:0] o_to_count
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          r_soft_reset;
  logic          w_idle;
  logic          w_expire;

  assign w_idle   = ~i_vld | i_rd;
  assign w_expire = ~w_idle &&
                    (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          r_cnt        <= '0;
          r_soft_reset <= 1'b0;
        end
        w_expire: begin
          r_cnt        <= '0;
          r_soft_reset <= 1'b1;
        end
        default: begin
          r_cnt        <= r_cnt + 1'b1;
          r_soft_reset <= 1'b0;
        end
      endcase
    end
  end

  assign o_soft_reset = r_soft_reset;

`ifdef ROUTER_SYNC_STAT_EN
  logic [STAT_W-1:0] r_to_count;

  // Counts on the edge that raises the pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_count <= '0;
    end else if (w_expire) begin
      r_to_count <= sat_inc(r_to_count);
    end
  end

  assign o_to_count = r_to_count;
`else
  assign o_to_count = '0;
`endif

endmodule

// File: rtl/router_sync_n.sv
// N-port router synchronizer: address latch, write steering, timeouts.
// Timeout statistics built only with ROUTER_SYNC_STAT_EN defined.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           din,
  input  logic                        detect_addr,
  input  logic                        wr_en_reg,
  input  logic [NUM_PORTS-1:0]        full,
  input  logic [NUM_PORTS-1:0]        empty,
  input  logic [NUM_PORTS-1:0]        rd_en,
  output logic [NUM_PORTS-1:0]        wr_en,
  output logic                        fifo_full,
  output logic                        addr_err,
  output logic [NUM_PORTS-1:0]        vld_out,
  output logic [NUM_PORTS-1:0]        soft_reset,
  output logic [NUM_PORTS*STAT_W-1:0] to_count
);

  logic [ADDR_W-1:0]    r_addr_q;
  logic [NUM_PORTS-1:0] w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_q <= '0;
    end else if (detect_addr) begin
      r_addr_q <= din;
    end
  end

  // One-hot decode; an out-of-range address hits nothing
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
    assign w_hit[i] = (r_addr_q == ADDR_W'(i));
  end

  assign addr_err  = ~|w_hit;
  assign wr_en     = wr_en_reg ? w_hit : '0;
  assign fifo_full = |(full & w_hit);
  assign vld_out   = ~empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_sync_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_vld        (vld_out[i]),
      .i_rd         (rd_en[i]),
      .o_soft_reset (soft_reset[i]),
      .o_to_count   (to_count[i*STAT_W +: STAT_W])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (3 ports, TIMEOUT=30).
// Stat expectations follow ROUTER_SYNC_STAT_EN.
module tb_router_sync_n;

`ifdef ROUTER_SYNC_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  din;
  logic        detect_addr;
  logic        wr_en_reg;
  logic [2:0]  full;
  logic [2:0]  empty;
  logic [2:0]  rd_en;
  logic [2:0]  wr_en;
  logic        fifo_full;
  logic        addr_err;
  logic [2:0]  vld_out;
  logic [2:0]  soft_reset;
  logic [23:0] to_count;

  int checks   = 0;
  int failures = 0;

  router_sync_n #(
    .NUM_PORTS (3),
    .ADDR_W    (2),
    .TIMEOUT   (30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .detect_addr (detect_addr),
    .wr_en_reg   (wr_en_reg),
    .full        (full),
    .empty       (empty),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .fifo_full   (fifo_full),
    .addr_err    (addr_err),
    .vld_out     (vld_out),
    .soft_reset  (soft_reset),
    .to_count    (to_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b0;
    din         = 2'd0;
    detect_addr = 1'b0;
    wr_en_reg   = 1'b1;
    full        = 3'b001;
    empty       = 3'b111;
    rd_en       = 3'b000;
    step();
    step();
    chk("rst_soft_reset", 32'(soft_reset), 32'h0);
    chk("rst_to_count", 32'(to_count), 32'h0);
    chk("rst_wr_en_port0", 32'(wr_en), 32'b001);
    chk("rst_fifo_full_port0", 32'(fifo_full), 32'h1);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_vld_out", 32'(vld_out), 32'h0);

    // Latch address 2
    rst         = 1'b1;
    full        = 3'b000;
    din         = 2'd2;
    detect_addr = 1'b1;
    #1;
    chk("wr_en_old_addr", 32'(wr_en), 32'b001);
    step();
    detect_addr = 1'b0;
    chk("wr_en_addr2", 32'(wr_en), 32'b100);
    full = 3'b100;
    #1;
    chk("fifo_full_addr2", 32'(fifo_full), 32'h1);
    wr_en_reg = 1'b0;
    #1;
    chk("wr_en_idle", 32'(wr_en), 32'h0);

    // Out-of-range address 3
    din         = 2'd3;
    detect_addr = 1'b1;
    step();
    detect_addr = 1'b0;
    wr_en_reg   = 1'b1;
    full        = 3'b111;
    #1;
    chk("addr_err_3", 32'(addr_err), 32'h1);
    chk("wr_en_addr3", 32'(wr_en), 32'h0);
    chk("fifo_full_addr3", 32'(fifo_full), 32'h0);

    // Address 1
    din         = 2'd1;
    detect_addr = 1'b1;
    step();
    detect_addr = 1'b0;
    full        = 3'b101;
    #1;
    chk("addr_err_1", 32'(addr_err), 32'h0);
    chk("wr_en_addr1", 32'(wr_en), 32'b010);
    chk("fifo_full_addr1", 32'(fifo_full), 32'h0);
    empty = 3'b010;
    #1;
    chk("vld_out_101", 32'(vld_out), 32'b101);
    empty     = 3'b111;
    wr_en_reg = 1'b0;
    step();

    // Port 0 stalls: pulses after edge 30 and edge 60
    empty = 3'b110;
    for (int n = 1; n <= 60; n++) begin
      step();
      chk($sformatf("t1_edge%0d", n), 32'(soft_reset),
          (n == 30 || n == 60) ? 32'b001 : 32'h0);
    end
    chk("t1_to_count0", 32'(to_count[7:0]),
        STAT ? 32'd2 : 32'd0);
    empty = 3'b111;
    step();
    chk("t1_cleared", 32'(soft_reset), 32'h0);

    // Read at edge 29 restarts the window
    empty = 3'b110;
    for (int n = 1; n <= 28; n++) begin
      step();
      chk($sformatf("t2_edge%0d", n), 32'(soft_reset), 32'h0);
    end
    rd_en = 3'b001;
    step();
    chk("t2_edge29_read", 32'(soft_reset), 32'h0);
    rd_en = 3'b000;
    for (int m = 1; m <= 30; m++) begin
      step();
      chk($sformatf("t2_after%0d", m), 32'(soft_reset),
          (m == 30) ? 32'b001 : 32'h0);
    end
    empty = 3'b111;
    step();

    // Ports 1 and 2 together
    empty = 3'b001;
    for (int n = 1; n <= 30; n++) begin
      step();
      chk($sformatf("t3_edge%0d", n), 32'(soft_reset),
          (n == 30) ? 32'b110 : 32'h0);
    end
    chk("t3_to_count", 32'(to_count),
        STAT ? 32'h01_01_03 : 32'h0);
    empty = 3'b111;
    step();

    // Reset mid-count
    empty = 3'b110;
    for (int n = 1; n <= 15; n++) step();
    rst = 1'b0;
    #1;
    chk("t4_rst_soft_reset", 32'(soft_reset), 32'h0);
    chk("t4_rst_to_count", 32'(to_count), 32'h0);
    step();
    #1;
    rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step();
      chk($sformatf("t4_edge%0d", n), 32'(soft_reset),
          (n == 30) ? 32'b001 : 32'h0);
    end
    chk("t4_to_count0", 32'(to_count[7:0]),
        STAT ? 32'd1 : 32'd0);
    empty = 3'b111;
    step();

    // Port 2: 256 timeouts saturate its counter
    empty = 3'b011;
    for (int n = 1; n <= 256 * 30; n++) step();
    chk("t5_pulse_after_sat", 32'(soft_reset), 32'b100);
    chk("t5_to_count2_sat", 32'(to_count[23:16]),
        STAT ? 32'd255 : 32'd0);
    chk("t5_to_count0_kept", 32'(to_count[7:0]),
        STAT ? 32'd1 : 32'd0);
    empty = 3'b111;
    step();
    chk("t5_idle", 32'(soft_reset), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
